aes_ctr_stream: RTL and testbench

- Parametrised AES counter-mode stream engine.
- Owns the {nonce, counter} block sequence and drives an external iterative AES encryption core through a start/done handshake.
- Prefetches keystream blocks into a small buffer and XORs them with a valid/ready data stream, so the same path serves encrypt and decrypt.
- Sits between the key-expanded encryption core and the system data path.

---
 rtl/aes_ctr_pkg.sv | 15 +
 rtl/aes_ctr_stream_if.sv | 27 ++
 rtl/aes_ctr_ks_fifo.sv | 72 +++++++
 rtl/aes_ctr_stream.sv | 124 ++++++++++++
 tb/tb_aes_ctr_stream.sv | 341 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_ctr_pkg.sv
// rtl/aes_ctr_pkg.sv - shared widths and request FSM encoding for aes_ctr_stream
package aes_ctr_pkg;

  localparam int BLOCK_W = 128;

  typedef logic [1:0] req_state_t;
  localparam req_state_t REQ_IDLE  = 2'd0;
  localparam req_state_t REQ_WAIT  = 2'd1;
  localparam req_state_t REQ_FLUSH = 2'd2;

  function automatic int nonce_w(input int ctr_w);
    return BLOCK_W - ctr_w;
  endfunction

endpackage

// File: rtl/aes_ctr_stream_if.sv
// rtl/aes_ctr_stream_if.sv - core start/done handshake plus in/out data streams
// slave is the engine view, master is the core/system view.
interface aes_ctr_stream_if;
  import aes_ctr_pkg::*;

  logic               core_start;
  logic [BLOCK_W-1:0] core_block;
  logic               core_done;
  logic [BLOCK_W-1:0] core_result;
  logic               in_valid;
  logic               in_ready;
  logic [BLOCK_W-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [BLOCK_W-1:0] out_data;

  modport slave (
    output core_start, core_block, in_ready, out_valid, out_data,
    input  core_done, core_result, in_valid, in_data, out_ready
  );

  modport master (
    input  core_start, core_block, in_ready, out_valid, out_data,
    output core_done, core_result, in_valid, in_data, out_ready
  );

endinterface

// File: rtl/aes_ctr_ks_fifo.sv
// rtl/aes_ctr_ks_fifo.sv - keystream block FIFO with synchronous flush
// Caller guarantees no push when full and no pop when empty.
module aes_ctr_ks_fifo
  import aes_ctr_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int LVL_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               flush,
  input  logic               push,
  input  logic [BLOCK_W-1:0] push_data,
  input  logic               pop,
  output logic [BLOCK_W-1:0] head,
  output logic [LVL_W-1:0]   level
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [BLOCK_W-1:0] mem_q [DEPTH];
  logic [BLOCK_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    level_d  = level_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign head  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/aes_ctr_stream.sv
// rtl/aes_ctr_stream.sv - AES-CTR keystream prefetch and XOR stream engine
// AES_CTR_WRAP_GUARD_EN: stop requesting after the all-ones counter block.
module aes_ctr_stream
  import aes_ctr_pkg::*;
#(
  parameter  int CTR_W    = 64,
  parameter  int KS_DEPTH = 2,
  localparam int NONCE_W  = nonce_w(CTR_W),
  localparam int LVL_W    = $clog2(KS_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               init,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   ctr_start,
  aes_ctr_stream_if.slave    bus,
  output logic [LVL_W-1:0]   ks_level,
  output logic               err_wrap
);

  logic               armed_q, armed_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  req_state_t         state_q, state_d;
  logic               out_valid_q, out_valid_d;
  logic [BLOCK_W-1:0] out_data_q, out_data_d;
  logic [BLOCK_W-1:0] ks_head;
  logic               req_go, done_take, in_fire, out_fire, wrap_block;

`ifdef AES_CTR_WRAP_GUARD_EN
  logic err_wrap_q, err_wrap_d;

  always_comb begin
    err_wrap_d = err_wrap_q;
    if (init) err_wrap_d = 1'b0;
    else if (req_go && (&ctr_q)) err_wrap_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) err_wrap_q <= 1'b0;
    else       err_wrap_q <= err_wrap_d;
  end

  assign wrap_block = err_wrap_q;
  assign err_wrap   = err_wrap_q;
`else
  assign wrap_block = 1'b0;
  assign err_wrap   = 1'b0;
`endif

  // In REQ_IDLE nothing is in flight, so ks_level alone bounds the prefetch.
  assign req_go    = armed_q && !init && (state_q == REQ_IDLE) &&
                     (ks_level < LVL_W'(KS_DEPTH)) && !wrap_block;
  assign done_take = (state_q == REQ_WAIT) && bus.core_done && !init;

  assign bus.core_start = req_go;
  assign bus.core_block = {nonce_q, ctr_q};

  assign bus.in_ready  = armed_q && !init && (ks_level != '0) &&
                         (!out_valid_q || bus.out_ready);
  assign bus.out_valid = out_valid_q && !init;
  assign bus.out_data  = out_data_q;
  assign in_fire       = bus.in_valid && bus.in_ready;
  assign out_fire      = bus.out_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_IDLE:  if (req_go) state_d = REQ_WAIT;
      // A done coinciding with init is the pending one; nothing left to discard.
      REQ_WAIT:  if (init) state_d = bus.core_done ? REQ_IDLE : REQ_FLUSH;
                 else if (bus.core_done) state_d = REQ_IDLE;
      REQ_FLUSH: if (bus.core_done) state_d = REQ_IDLE;
      default:   state_d = REQ_IDLE;
    endcase
  end

  always_comb begin
    armed_d     = armed_q || init;
    nonce_d     = init ? nonce : nonce_q;
    ctr_d       = ctr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (init)           ctr_d = ctr_start;
    else if (done_take) ctr_d = ctr_q + 1'b1;
    if (init)          out_valid_d = 1'b0;
    else if (in_fire)  out_valid_d = 1'b1;
    else if (out_fire) out_valid_d = 1'b0;
    if (in_fire) out_data_d = bus.in_data ^ ks_head;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      armed_q     <= 1'b0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      state_q     <= REQ_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      armed_q     <= armed_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  aes_ctr_ks_fifo #(
    .DEPTH (KS_DEPTH),
    .LVL_W (LVL_W)
  ) u_ks_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (init),
    .push      (done_take),
    .push_data (bus.core_result),
    .pop       (in_fire),
    .head      (ks_head),
    .level     (ks_level)
  );

endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb/tb_aes_ctr_stream.sv - directed self-checking bench for aes_ctr_stream
module tb_aes_ctr_stream;
  import aes_ctr_pkg::*;

  localparam int CTR_W    = 64;
  localparam int KS_DEPTH = 2;
  localparam int LVL_W    = $clog2(KS_DEPTH + 1);
  localparam logic [63:0]  NONCE = 64'h0123456789ABCDEF;
  localparam logic [127:0] PAT   = {32{4'hA}};
  localparam logic [127:0] DAT   = 128'hDEADBEEF_00000000_CAFEF00D_12345678;
`ifdef AES_CTR_WRAP_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             init;
  logic [63:0]      nonce;
  logic [63:0]      ctr_start;
  logic [LVL_W-1:0] ks_level;
  logic             err_wrap;

  int checks = 0;
  int errors = 0;

  aes_ctr_stream_if bus();

  aes_ctr_stream #(.CTR_W(CTR_W), .KS_DEPTH(KS_DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .init      (init),
    .nonce     (nonce),
    .ctr_start (ctr_start),
    .bus       (bus),
    .ks_level  (ks_level),
    .err_wrap  (err_wrap)
  );

  always #5 clk = ~clk;

  // Core stub: result = block ^ PAT, done pulse a fixed latency after start.
  int             stub_cnt = 0;
  int             starts   = 0;
  int             dones    = 0;
  logic [127:0]   stub_blk;
  logic [127:0]   blk_log[$];

  always @(posedge clk) begin
    bus.core_done <= 1'b0;
    if (stub_cnt == 1) begin
      bus.core_done   <= 1'b1;
      bus.core_result <= stub_blk ^ PAT;
      dones           <= dones + 1;
    end
    if (stub_cnt > 0) stub_cnt <= stub_cnt - 1;
    if (bus.core_start === 1'b1) begin
      stub_blk <= bus.core_block;
      stub_cnt <= 10;
      starts   <= starts + 1;
      blk_log.push_back(bus.core_block);
    end
  end

  function automatic logic [127:0] ks(input logic [63:0] c);
    return {NONCE, c} ^ PAT;
  endfunction

  task automatic init_pulse(input logic [63:0] c);
    @(posedge clk); #1;
    init = 1'b1; nonce = NONCE; ctr_start = c;
    @(posedge clk); #1;
    init = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; init = 1'b0; nonce = '0; ctr_start = '0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.core_start !== 1'b0 || bus.core_block !== '0 || bus.in_ready !== 1'b0 ||
        bus.out_valid !== 1'b0 || bus.out_data !== '0 || ks_level !== '0 || err_wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: start=%b blk=%h ir=%b ov=%b od=%h lvl=%0d ew=%b, want all 0",
               bus.core_start, bus.core_block, bus.in_ready, bus.out_valid, bus.out_data, ks_level, err_wrap);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (starts !== 0) begin
      errors++;
      $display("FAIL unarmed_no_start: starts=%0d want 0", starts);
    end
  endtask

  task automatic test_prefetch();
    init_pulse(64'd0);
    @(negedge clk);
    checks++;
    if (bus.core_start !== 1'b1) begin
      errors++;
      $display("FAIL start_after_arm: core_start=%b want 1", bus.core_start);
    end
    for (int i = 0; i < 60 && ks_level != 2; i++) @(negedge clk);
    checks++;
    if (ks_level !== 2'd2) begin
      errors++;
      $display("FAIL prefetch_level: ks_level=%0d want 2", ks_level);
    end
    checks++;
    if (blk_log.size() < 2) begin
      errors++;
      $display("FAIL prefetch_blocks: %0d requests want 2", blk_log.size());
    end else if (blk_log[0] !== {NONCE, 64'd0} || blk_log[1] !== {NONCE, 64'd1}) begin
      errors++;
      $display("FAIL prefetch_blocks: got %h %h want %h %h",
               blk_log[0], blk_log[1], {NONCE, 64'd0}, {NONCE, 64'd1});
    end
    repeat (15) @(negedge clk);
    checks++;
    if (starts !== 2 || ks_level !== 2'd2) begin
      errors++;
      $display("FAIL prefetch_bound: starts=%0d lvl=%0d want 2 2", starts, ks_level);
    end
  endtask

  task automatic test_stream();
    int n_in = 0;
    int n_out = 0;
    bit pend = 1'b0;
    logic [127:0] exp;
    @(posedge clk); #1;
    bus.out_ready = 1'b1; bus.in_data = '0; bus.in_valid = 1'b1;
    for (int i = 0; i < 200 && n_out < 4; i++) begin
      @(negedge clk);
      if (pend) begin
        exp = ks(64'(n_out));
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== exp) begin
          errors++;
          $display("FAIL stream_out%0d: ov=%b data=%h want 1 %h", n_out, bus.out_valid, bus.out_data, exp);
        end
        n_out++;
        pend = 1'b0;
      end
      if (bus.in_valid && bus.in_ready) begin
        n_in++;
        pend = 1'b1;
      end
      @(posedge clk); #1;
      if (n_in == 4) bus.in_valid = 1'b0;
    end
    checks++;
    if (n_out != 4) begin
      errors++;
      $display("FAIL stream_count: %0d outputs want 4", n_out);
    end
  endtask

  task automatic test_back_pressure();
    for (int i = 0; i < 60 && ks_level != 2; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_data = DAT; bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_first_ready: in_ready=%b want 1", bus.in_ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== (DAT ^ ks(64'd4)) || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: ov=%b data=%h ir=%b want 1 %h 0",
                 i, bus.out_valid, bus.out_data, bus.in_ready, DAT ^ ks(64'd4));
      end
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release_ready: in_ready=%b want 1", bus.in_ready);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== (DAT ^ ks(64'd5))) begin
      errors++;
      $display("FAIL bp_next: ov=%b data=%h want 1 %h", bus.out_valid, bus.out_data, DAT ^ ks(64'd5));
    end
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_drain: out_valid=%b want 0", bus.out_valid);
    end
  endtask

  task automatic test_init_flush();
    int d0;
    int i;
    for (i = 0; i < 40 && bus.core_start !== 1'b1; i++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1 init = 1'b1; nonce = NONCE; ctr_start = 64'd100;
    @(posedge clk); #1;
    init = 1'b0;
    d0 = dones;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || ks_level !== '0 || bus.core_start !== 1'b0) begin
      errors++;
      $display("FAIL flush_state: ov=%b lvl=%0d start=%b want 0 0 0", bus.out_valid, ks_level, bus.core_start);
    end
    for (i = 0; i < 20 && dones == d0; i++) @(negedge clk);
    @(negedge clk);
    checks++;
    if (ks_level !== '0 || bus.core_start !== 1'b1 || bus.core_block !== {NONCE, 64'd100}) begin
      errors++;
      $display("FAIL flush_discard: lvl=%0d start=%b blk=%h want 0 1 %h",
               ks_level, bus.core_start, bus.core_block, {NONCE, 64'd100});
    end
    for (i = 0; i < 30 && ks_level == 0; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.in_data = '0; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ks(64'd100)) begin
      errors++;
      $display("FAIL flush_first_out: ov=%b data=%h want 1 %h", bus.out_valid, bus.out_data, ks(64'd100));
    end
  endtask

  task automatic test_reset_mid();
    int s0;
    for (int i = 0; i < 40 && ks_level == 0; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.out_ready = 1'b0; bus.in_data = DAT; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_setup: out_valid=%b want 1", bus.out_valid);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    s0 = starts;
    @(negedge clk);
    checks++;
    if (bus.core_start !== 1'b0 || bus.core_block !== '0 || bus.in_ready !== 1'b0 ||
        bus.out_valid !== 1'b0 || bus.out_data !== '0 || ks_level !== '0 || err_wrap !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_state: start=%b blk=%h ir=%b ov=%b od=%h lvl=%0d ew=%b, want all 0",
               bus.core_start, bus.core_block, bus.in_ready, bus.out_valid, bus.out_data, ks_level, err_wrap);
    end
    repeat (25) @(negedge clk);
    checks++;
    if (starts !== s0 || ks_level !== '0) begin
      errors++;
      $display("FAIL rst_mid_idle: starts=%0d lvl=%0d want %0d 0", starts, ks_level, s0);
    end
  endtask

  task automatic test_wrap();
    int s0;
    bus.out_ready = 1'b1;
    init_pulse(64'hFFFF_FFFF_FFFF_FFFF);
    s0 = starts;
    @(negedge clk);
    checks++;
    if (bus.core_start !== 1'b1 || bus.core_block !== {NONCE, 64'hFFFF_FFFF_FFFF_FFFF} || err_wrap !== 1'b0) begin
      errors++;
      $display("FAIL wrap_first: start=%b blk=%h ew=%b want 1 %h 0",
               bus.core_start, bus.core_block, err_wrap, {NONCE, 64'hFFFF_FFFF_FFFF_FFFF});
    end
    @(negedge clk);
    checks++;
    if (err_wrap !== GUARD) begin
      errors++;
      $display("FAIL wrap_err_timing: err_wrap=%b want %b", err_wrap, GUARD);
    end
    repeat (40) @(negedge clk);
    checks++;
    if (GUARD) begin
      if (starts - s0 != 1 || err_wrap !== 1'b1 || ks_level !== 2'd1) begin
        errors++;
        $display("FAIL wrap_guard: starts=%0d ew=%b lvl=%0d want 1 1 1", starts - s0, err_wrap, ks_level);
      end
    end else begin
      if (blk_log.size() < s0 + 2 || err_wrap !== 1'b0 || ks_level !== 2'd2) begin
        errors++;
        $display("FAIL wrap_silent: requests=%0d ew=%b lvl=%0d want 2 0 2", blk_log.size() - s0, err_wrap, ks_level);
      end else if (blk_log[s0+1] !== {NONCE, 64'd0}) begin
        errors++;
        $display("FAIL wrap_silent_blk: got %h want %h", blk_log[s0+1], {NONCE, 64'd0});
      end
    end
    @(posedge clk); #1;
    bus.in_data = '0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== ks(64'hFFFF_FFFF_FFFF_FFFF)) begin
      errors++;
      $display("FAIL wrap_drain: ov=%b data=%h want 1 %h",
               bus.out_valid, bus.out_data, ks(64'hFFFF_FFFF_FFFF_FFFF));
    end
  endtask

  initial begin
    test_reset();
    test_prefetch();
    test_stream();
    test_back_pressure();
    test_init_flush();
    test_reset_mid();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
